// File: rtl/regfile_writeback_pkg.sv
// regfile_writeback_pkg: shared constants and the queued write-back entry type
package regfile_writeback_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: circular buffer of pending LSU write-back entries
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   resetControl_n,
    input  logic                   push,
    input  logic                   pop,
    input  wb_entry_t              din,
    output wb_entry_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    wb_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [PW:0] count_d, count_q;
    logic push_ok, pop_ok;
    assign full  = count_q == (PW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
    always_ff @(posedge clock or negedge resetControl_n) begin
        if (!resetControl_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: register-file write port arbiter merging ALU results with queued LSU results
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   resetControl_n,
    input  logic                   alu_valid,
    input  logic [ADDR_WIDTH-1:0]  alu_rd,
    input  logic [DATA_WIDTH-1:0]  alu_data,
    input  logic                   lsu_valid,
    input  logic [ADDR_WIDTH-1:0]  lsu_rd,
    input  logic [DATA_WIDTH-1:0]  lsu_data,
    output logic                   lsu_ready,
    input  logic                   issue_valid,
    input  logic [ADDR_WIDTH-1:0]  issue_rd,
    input  logic [ADDR_WIDTH-1:0]  query_rs,
    input  logic [ADDR_WIDTH-1:0]  query_rt,
    input  logic [ADDR_WIDTH-1:0]  query_rd,
    output logic                   stall,
    output logic                   we,
    output logic [ADDR_WIDTH-1:0]  rd,
    output logic [DATA_WIDTH-1:0]  input_data,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int NREG = 2 ** ADDR_WIDTH;
    wb_entry_t lsu_entry, head;
    logic full, empty, alu_sel, pop, push, we_d, we_q;
    logic [ADDR_WIDTH-1:0] rd_d, rd_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic [NREG-1:0] pending_d, pending_q, set, clr;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock          (clock),
        .resetControl_n (resetControl_n),
        .push           (push),
        .pop            (pop),
        .din            (lsu_entry),
        .dout           (head),
        .full           (full),
        .empty          (empty),
        .count          (fifo_count)
    );
    always_comb begin
        alu_sel   = alu_valid && alu_rd != REG_ZERO;
        pop       = !alu_sel && !empty;
        push      = lsu_valid && !full && lsu_rd != REG_ZERO;
        lsu_entry = '{rd: lsu_rd, data: lsu_data};
        we_d      = alu_sel || pop;
        rd_d      = alu_sel ? alu_rd : pop ? head.rd : rd_q;
        data_d    = alu_sel ? alu_data : pop ? head.data : data_q;
        set       = issue_valid ? NREG'(1) << issue_rd : '0;
        clr       = pop ? NREG'(1) << head.rd : '0;
        // set is OR-ed after the clear so a same-cycle re-issue keeps the bit
        pending_d = ((pending_q & ~clr) | set) & ~NREG'(1);
    end
    always_ff @(posedge clock or negedge resetControl_n) begin
        if (!resetControl_n) begin
            we_q      <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            we_q      <= we_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end
    assign we         = we_q;
    assign rd         = rd_q;
    assign input_data = data_q;
    assign lsu_ready  = !full;
    assign stall      = pending_q[query_rs] | pending_q[query_rt] | pending_q[query_rd];
    // a register freed by this cycle's pop may legally be re-issued
    a_no_pending_issue: assert property (@(posedge clock) disable iff (!resetControl_n)
        !(issue_valid && issue_rd != REG_ZERO && pending_q[issue_rd] && !clr[issue_rd]));
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed and random checks of regfile_writeback against a queue-based model
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;
    localparam int DEPTH = 4;
    logic clock = 1'b0, resetControl_n = 1'b0;
    logic alu_valid, lsu_valid, issue_valid;
    logic [4:0] alu_rd, lsu_rd, issue_rd, query_rs, query_rt, query_rd;
    logic [31:0] alu_data, lsu_data;
    logic lsu_ready, stall, we;
    logic [4:0] rd;
    logic [31:0] input_data;
    logic [2:0] fifo_count;
    int n_chk = 0, n_fail = 0;
    wb_entry_t m_q[$];
    bit [31:0] m_pend;
    bit m_we;
    bit [4:0] m_rd;
    bit [31:0] m_data;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clock(clock), .resetControl_n(resetControl_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .query_rs(query_rs), .query_rt(query_rt), .query_rd(query_rd), .stall(stall),
        .we(we), .rd(rd), .input_data(input_data), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0;
        query_rs = 0; query_rt = 0; query_rd = 0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = 0; m_we = 0; m_rd = 0; m_data = 0;
    endtask

    // One clock of the reference behaviour, evaluated from the inputs and the pre-edge state
    task automatic model_edge();
        wb_entry_t e;
        bit accept;
        accept = lsu_valid && m_q.size() < DEPTH && lsu_rd != 0;
        if (alu_valid && alu_rd != 0) begin
            m_we = 1; m_rd = alu_rd; m_data = alu_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_we = 1; m_rd = e.rd; m_data = e.data;
            m_pend[e.rd] = 0;
        end else m_we = 0;
        if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
        if (accept) begin
            e.rd = lsu_rd; e.data = lsu_data;
            m_q.push_back(e);
        end
    endtask

    task automatic check_all();
        chk("we", 32'(we), 32'(m_we));
        chk("rd", 32'(rd), 32'(m_rd));
        chk("input_data", input_data, m_data);
        chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("lsu_ready", 32'(lsu_ready), 32'(m_q.size() < DEPTH));
        chk("stall", 32'(stall), 32'(m_pend[query_rs] | m_pend[query_rt] | m_pend[query_rd]));
    endtask

    task automatic step();
        model_edge();
        @(posedge clock); #1;
        check_all();
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_we", 32'(we), 0);
        chk("reset_count", 32'(fifo_count), 0);
        @(negedge clock) resetControl_n = 1;
        @(posedge clock); #1;
        step();

        // ALU-only write
        alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF;
        step();
        chk("alu_only_data", input_data, 32'hDEADBEEF);
        chk("alu_only_rd", 32'(rd), 3);

        // ALU priority over a queued LSU entry
        alu_rd = 1; alu_data = 32'h1;
        lsu_valid = 1; lsu_rd = 5; lsu_data = 32'h22;
        step();
        lsu_valid = 0; alu_rd = 4; alu_data = 32'h11;
        step();
        chk("prio_alu_rd", 32'(rd), 4);
        idle();
        step();
        chk("prio_lsu_rd", 32'(rd), 5);
        chk("prio_lsu_data", input_data, 32'h22);

        // Fill to full under continuous ALU traffic, offer a fifth, then drain
        alu_valid = 1; alu_rd = 1;
        for (int i = 0; i < 5; i++) begin
            alu_data = $urandom;
            lsu_valid = 1; lsu_rd = 5'(10 + i); lsu_data = 32'h100 + 32'(i);
            step();
        end
        chk("full_count", 32'(fifo_count), 4);
        chk("full_ready", 32'(lsu_ready), 0);
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_rd", 32'(rd), 32'(10 + i));
        end
        chk("drain_ready", 32'(lsu_ready), 1);

        // Scoreboard set, clear on pop, set-wins on re-issue in the pop cycle
        issue_valid = 1; issue_rd = 7; query_rs = 7;
        step();
        chk("sb_set", 32'(stall), 1);
        issue_valid = 0; lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hCAFE;
        step();
        lsu_valid = 0;
        step();
        chk("sb_clear_rd", 32'(rd), 7);
        chk("sb_clear", 32'(stall), 0);
        issue_valid = 1;
        step();
        issue_valid = 0; lsu_valid = 1; lsu_data = 32'hCAFF;
        step();
        lsu_valid = 0; issue_valid = 1;
        step();
        chk("sb_set_wins", 32'(stall), 1);
        issue_valid = 0; lsu_valid = 1; lsu_data = 32'hCB00;
        step();
        idle();
        step();

        // Register zero handling
        alu_valid = 1; alu_rd = 1; lsu_valid = 1; lsu_rd = 12; lsu_data = 32'h1212;
        step();
        lsu_valid = 0; alu_rd = 0; alu_data = 32'hBAD;
        step();
        chk("zero_alu_rd", 32'(rd), 12);
        idle();
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h5;
        step();
        chk("zero_lsu_count", 32'(fifo_count), 0);
        idle();
        issue_valid = 1; issue_rd = 0;
        step();
        chk("zero_issue_stall", 32'(stall), 0);

        // Async reset with three queued entries and pending[9]
        idle();
        issue_valid = 1; issue_rd = 9;
        step();
        issue_valid = 0; alu_valid = 1; alu_rd = 1; lsu_valid = 1;
        for (int i = 0; i < 3; i++) begin
            lsu_rd = 5'(9 + i); lsu_data = $urandom;
            step();
        end
        idle();
        query_rs = 9;
        #2 resetControl_n = 0;
        #1;
        model_reset();
        chk("arst_we", 32'(we), 0);
        chk("arst_count", 32'(fifo_count), 0);
        chk("arst_stall", 32'(stall), 0);
        @(posedge clock);
        @(negedge clock) resetControl_n = 1;
        @(posedge clock); #1;
        check_all();
        step();
        chk("arst_no_write", 32'(we), 0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            alu_valid = $urandom_range(0, 1) == 1;
            alu_rd = 5'($urandom_range(0, 31));
            alu_data = $urandom;
            lsu_valid = $urandom_range(0, 2) != 0;
            lsu_rd = 5'($urandom_range(0, 31));
            lsu_data = $urandom;
            issue_rd = 5'($urandom_range(0, 31));
            issue_valid = $urandom_range(0, 1) == 1 && !m_pend[issue_rd];
            query_rs = 5'($urandom_range(0, 31));
            query_rt = 5'($urandom_range(0, 31));
            query_rd = 5'($urandom_range(0, 31));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
